mem_port_arbiter: RTL

//  Shares one single-ported, variable-latency memory between the instruction-fetch requester (PC/IF stage)
//  and the data requester (MEM stage). Arbitrates, sequences one transaction at a time through an FSM,

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, variable-latency memory between the instruction
//   fetch requester and the data (MEM stage) requester. Only one transaction is
//   in flight at a time. Data has priority, and a starvation counter bounds how
//   many consecutive data grants can pass a waiting fetch.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   if_req_i, if_addr_i      fetch request (level) and address
//   if_rdata_o, if_ack_o     fetch read data (held) and one-cycle completion pulse
//   if_stall_o               fetch stall to the pipeline
//   d_req_i, d_we_i          data request (level) and write enable
//   d_addr_i, d_wdata_i      data address and write data
//   d_rdata_o, d_ack_o       data read data (held) and one-cycle completion pulse
//   d_stall_o                data stall to the pipeline
//   mem_req_o, mem_we_o      memory request (held until ready) and write enable
//   mem_addr_o, mem_wdata_o  registered memory address and write data
//   mem_ready_i, mem_rdata_i memory completion and read data
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_ack_o,
  output logic          if_stall_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_ack_o,
  output logic          d_stall_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ready_i,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int unsigned   CW      = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic          own_d_q, own_d_d;      // 1 = data requester owns the transaction
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant_d;

  // Data wins unless a fetch is waiting and the data side has already used up
  // its allowance of consecutive grants.
  always_comb begin
    grant_d = d_req_i && !(if_req_i && (STARVE_MAX != 0) && (cnt_q == CNT_MAX));
  end

  always_comb begin
    state_d     = state_q;
    own_d_d     = own_d_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (d_req_i || if_req_i) begin
          state_d   = S_WAIT;
          mem_req_d = 1'b1;
          own_d_d   = grant_d;
          if (grant_d) begin
            mem_we_d    = d_we_i;
            mem_addr_d  = d_addr_i;
            mem_wdata_d = d_wdata_i;
            if (!if_req_i) begin
              cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
            cnt_d       = '0;
          end
        end
      end
      S_WAIT: begin
        if (mem_ready_i) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          if (own_d_q) begin
            d_ack_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata_i;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      own_d_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      own_d_q     <= own_d_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      cnt_q       <= cnt_d;
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign if_stall_o  = if_req_i & ~if_ack_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_ack_o     = d_ack_q;
  assign d_stall_o   = d_req_i & ~d_ack_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
